// File: rtl/dcache_mem_arbiter_if.sv
// +-----------------------------------------------------------------------------+
// | dcache_mem_arbiter_if : refill/writeback requester and memory-bus signals   |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

interface dcache_mem_arbiter_if #(
   parameter int LINE_ADDR_W = 28,
   parameter int LINE_W      = 128
);
   logic                   rd_req_valid;
   logic                   rd_req_ready;
   logic [LINE_ADDR_W-1:0] rd_req_addr;
   logic                   rd_resp_valid;
   logic [LINE_W-1:0]      rd_resp_data;

   logic                   wb_req_valid;
   logic                   wb_req_ready;
   logic [LINE_ADDR_W-1:0] wb_req_addr;
   logic [LINE_W-1:0]      wb_req_data;

   logic                   mem_valid;
   logic                   mem_ready;
   logic                   mem_wen;
   logic [31:0]            mem_addr;
   logic [LINE_W-1:0]      mem_wdata;
   logic                   mem_rvalid;
   logic [LINE_W-1:0]      mem_rdata;

   modport slave (
      input  rd_req_valid, rd_req_addr,
      input  wb_req_valid, wb_req_addr, wb_req_data,
      input  mem_ready, mem_rvalid, mem_rdata,
      output rd_req_ready, rd_resp_valid, rd_resp_data,
      output wb_req_ready,
      output mem_valid, mem_wen, mem_addr, mem_wdata
   );

   modport master (
      output rd_req_valid, rd_req_addr,
      output wb_req_valid, wb_req_addr, wb_req_data,
      output mem_ready, mem_rvalid, mem_rdata,
      input  rd_req_ready, rd_resp_valid, rd_resp_data,
      input  wb_req_ready,
      input  mem_valid, mem_wen, mem_addr, mem_wdata
   );
endinterface

`default_nettype wire

// File: rtl/dcache_mem_arbiter.sv
// +-----------------------------------------------------------------------------+
// | dcache_mem_arbiter : D-cache memory-port arbiter, refill vs. writeback      |
// | Optional perf counters: define DCACHE_ARB_PERF_EN.        Rev 1.0           |
// +-----------------------------------------------------------------------------+
`default_nettype none

module dcache_mem_arbiter #(
   parameter int MAX_RD_STREAK = 4,
   parameter int LINE_ADDR_W   = 28,
   parameter int LINE_W        = 128
) (
   input  logic                 clk,
   input  logic                 rst,
   dcache_mem_arbiter_if.slave  arb_if,
   output logic                 busy_o
`ifdef DCACHE_ARB_PERF_EN
  ,output logic [31:0]          perf_rd_grants_o,
   output logic [31:0]          perf_wb_grants_o,
   output logic [31:0]          perf_raw_stalls_o
`endif
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WR_ISSUE = 2'd1,
      RD_ISSUE = 2'd2,
      RD_WAIT  = 2'd3
   } state_e;

   localparam int                  STREAK_W   = 4;
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_RD_STREAK);

   state_e                state_q, state_d;
   logic                  mem_valid_q, mem_valid_d;
   logic                  mem_wen_q, mem_wen_d;
   logic [31:0]           mem_addr_q, mem_addr_d;
   logic [LINE_W-1:0]     mem_wdata_q, mem_wdata_d;
   logic                  rd_resp_valid_q, rd_resp_valid_d;
   logic [LINE_W-1:0]     rd_resp_data_q, rd_resp_data_d;
   logic [STREAK_W-1:0]   streak_q, streak_d;

   logic both_valid, raw_hit, grant_wr, grant_rd;

   // A read to a line whose dirty copy is still queued must wait for the write.
   always_comb begin
      both_valid = arb_if.rd_req_valid & arb_if.wb_req_valid;
      raw_hit    = both_valid & (arb_if.rd_req_addr == arb_if.wb_req_addr);
      grant_wr   = 1'b0;
      grant_rd   = 1'b0;
      if (state_q == IDLE) begin
         if (raw_hit || (both_valid && streak_q == STREAK_MAX)) begin
            grant_wr = 1'b1;
         end else if (arb_if.rd_req_valid) begin
            grant_rd = 1'b1;
         end else if (arb_if.wb_req_valid) begin
            grant_wr = 1'b1;
         end
      end
   end

   always_comb begin
      state_d         = state_q;
      mem_valid_d     = mem_valid_q;
      mem_wen_d       = mem_wen_q;
      mem_addr_d      = mem_addr_q;
      mem_wdata_d     = mem_wdata_q;
      rd_resp_valid_d = 1'b0;
      rd_resp_data_d  = rd_resp_data_q;
      streak_d        = streak_q;
      case (state_q)
         IDLE: begin
            if (grant_wr) begin
               state_d     = WR_ISSUE;
               mem_valid_d = 1'b1;
               mem_wen_d   = 1'b1;
               mem_addr_d  = 32'({arb_if.wb_req_addr, 4'b0000});
               mem_wdata_d = arb_if.wb_req_data;
               streak_d    = '0;
            end else if (grant_rd) begin
               state_d     = RD_ISSUE;
               mem_valid_d = 1'b1;
               mem_wen_d   = 1'b0;
               mem_addr_d  = 32'({arb_if.rd_req_addr, 4'b0000});
               if (!arb_if.wb_req_valid) begin
                  streak_d = '0;
               end else if (streak_q < STREAK_MAX) begin
                  streak_d = streak_q + 1'b1;
               end
            end
         end
         WR_ISSUE: begin
            if (arb_if.mem_ready) begin
               state_d     = IDLE;
               mem_valid_d = 1'b0;
            end
         end
         RD_ISSUE: begin
            // A return coincident with the handshake is not legal and is ignored.
            if (arb_if.mem_ready) begin
               state_d     = RD_WAIT;
               mem_valid_d = 1'b0;
            end
         end
         RD_WAIT: begin
            if (arb_if.mem_rvalid) begin
               state_d         = IDLE;
               rd_resp_valid_d = 1'b1;
               rd_resp_data_d  = arb_if.mem_rdata;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= IDLE;
         mem_valid_q     <= 1'b0;
         mem_wen_q       <= 1'b0;
         mem_addr_q      <= '0;
         mem_wdata_q     <= '0;
         rd_resp_valid_q <= 1'b0;
         rd_resp_data_q  <= '0;
         streak_q        <= '0;
      end else begin
         state_q         <= state_d;
         mem_valid_q     <= mem_valid_d;
         mem_wen_q       <= mem_wen_d;
         mem_addr_q      <= mem_addr_d;
         mem_wdata_q     <= mem_wdata_d;
         rd_resp_valid_q <= rd_resp_valid_d;
         rd_resp_data_q  <= rd_resp_data_d;
         streak_q        <= streak_d;
      end
   end

   assign arb_if.rd_req_ready  = grant_rd;
   assign arb_if.wb_req_ready  = grant_wr;
   assign arb_if.mem_valid     = mem_valid_q;
   assign arb_if.mem_wen       = mem_wen_q;
   assign arb_if.mem_addr      = mem_addr_q;
   assign arb_if.mem_wdata     = mem_wdata_q;
   assign arb_if.rd_resp_valid = rd_resp_valid_q;
   assign arb_if.rd_resp_data  = rd_resp_data_q;
   assign busy_o               = (state_q != IDLE);

`ifdef DCACHE_ARB_PERF_EN
   logic [31:0] perf_rd_q, perf_wb_q, perf_raw_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_rd_q  <= '0;
         perf_wb_q  <= '0;
         perf_raw_q <= '0;
      end else begin
         if (grant_rd) perf_rd_q <= perf_rd_q + 32'd1;
         if (grant_wr) perf_wb_q <= perf_wb_q + 32'd1;
         if (raw_hit && state_q == IDLE) perf_raw_q <= perf_raw_q + 32'd1;
      end
   end

   assign perf_rd_grants_o  = perf_rd_q;
   assign perf_wb_grants_o  = perf_wb_q;
   assign perf_raw_stalls_o = perf_raw_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dcache_mem_arbiter.sv
// +-----------------------------------------------------------------------------+
// | tb_dcache_mem_arbiter : scoreboard bench for dcache_mem_arbiter             |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_dcache_mem_arbiter;
   localparam int LAW      = 28;
   localparam int LW       = 128;
   localparam int RD_DELAY = 3;

   typedef struct packed {
      logic          wen;
      logic [31:0]   addr;
      logic [LW-1:0] data;
   } mem_tx_t;

   typedef struct packed {
      logic [LAW-1:0] addr;
      logic [LW-1:0]  data;
   } wb_req_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy;
`ifdef DCACHE_ARB_PERF_EN
   logic [31:0] perf_rd, perf_wb, perf_raw;
   logic [31:0] perf_rd0, perf_wb0, perf_raw0;
`endif

   dcache_mem_arbiter_if #(.LINE_ADDR_W(LAW), .LINE_W(LW)) arb_if ();

   dcache_mem_arbiter #(
      .MAX_RD_STREAK (4),
      .LINE_ADDR_W   (LAW),
      .LINE_W        (LW)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .arb_if  (arb_if),
      .busy_o  (busy)
`ifdef DCACHE_ARB_PERF_EN
     ,.perf_rd_grants_o  (perf_rd),
      .perf_wb_grants_o  (perf_wb),
      .perf_raw_stalls_o (perf_raw)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [LAW-1:0] rd_q[$];
   wb_req_t        wb_q[$];
   mem_tx_t        exp_mem_q[$];
   logic [LW-1:0]  exp_resp_q[$];

   bit          rd_take = 0, wb_take = 0, took_last = 0;
   bit          resp_due = 0, resp_due_nx = 0, force_rvalid = 0;
   int          rd_cnt = 0, stall_cnt = 0;
   logic [31:0] rd_addr_pend = '0;

   task automatic check_val(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Memory contents; the line at byte address 0x1230 reads back as all 0xA5.
   function automatic logic [LW-1:0] mem_line(input logic [31:0] a);
      return {4{32'hA5A5_A5A5 ^ (a - 32'h0000_1230)}};
   endfunction

   function automatic mem_tx_t mk_tx(input logic wen, input logic [31:0] addr, input logic [LW-1:0] data);
      mem_tx_t t;
      t.wen  = wen;
      t.addr = addr;
      t.data = data;
      return t;
   endfunction

   function automatic wb_req_t mk_wb(input logic [LAW-1:0] addr, input logic [LW-1:0] data);
      wb_req_t w;
      w.addr = addr;
      w.data = data;
      return w;
   endfunction

   // One negedge step: drive requesters and memory, then sample and score.
   task automatic tick();
      mem_tx_t t;
      resp_due    = resp_due_nx;
      resp_due_nx = 0;
      if (rd_take) void'(rd_q.pop_front());
      if (wb_take) void'(wb_q.pop_front());

      arb_if.rd_req_valid = (rd_q.size() != 0);
      arb_if.rd_req_addr  = (rd_q.size() != 0) ? rd_q[0] : '0;
      arb_if.wb_req_valid = (wb_q.size() != 0);
      arb_if.wb_req_addr  = (wb_q.size() != 0) ? wb_q[0].addr : '0;
      arb_if.wb_req_data  = (wb_q.size() != 0) ? wb_q[0].data : '0;

      arb_if.mem_rvalid = 1'b0;
      arb_if.mem_rdata  = '0;
      if (rd_cnt > 0) begin
         rd_cnt--;
         if (rd_cnt == 0) begin
            arb_if.mem_rvalid = 1'b1;
            arb_if.mem_rdata  = mem_line(rd_addr_pend);
            exp_resp_q.push_back(mem_line(rd_addr_pend));
            resp_due_nx = 1;
         end
      end
      if (force_rvalid) begin
         arb_if.mem_rvalid = 1'b1;
         arb_if.mem_rdata  = {4{32'hDEAD_BEEF}};
         force_rvalid      = 0;
      end
      arb_if.mem_ready = (stall_cnt == 0);

      #1;
      check_val("resp_timing", arb_if.rd_resp_valid, resp_due);
      if (arb_if.rd_resp_valid && exp_resp_q.size() != 0)
         check_val("resp_data", arb_if.rd_resp_data, exp_resp_q.pop_front());
      check_val("ready_onehot", arb_if.rd_req_ready & arb_if.wb_req_ready, 1'b0);
      if (arb_if.mem_valid)
         check_val("ready_while_busy", arb_if.rd_req_ready | arb_if.wb_req_ready, 1'b0);
      if (took_last)
         check_val("grant_latency", arb_if.mem_valid, 1'b1);

      if (exp_mem_q.size() == 0) begin
         check_val("mem_unexpected", arb_if.mem_valid, 1'b0);
      end else if (arb_if.mem_valid) begin
         t = exp_mem_q[0];
         check_val("mem_wen", arb_if.mem_wen, t.wen);
         check_val("mem_addr", arb_if.mem_addr, t.addr);
         if (t.wen) check_val("mem_wdata", arb_if.mem_wdata, t.data);
         if (arb_if.mem_ready) begin
            void'(exp_mem_q.pop_front());
            if (!t.wen) begin
               rd_cnt       = RD_DELAY;
               rd_addr_pend = t.addr;
            end
         end else if (stall_cnt > 0) begin
            stall_cnt--;
         end
      end

      rd_take   = !rst && arb_if.rd_req_valid && arb_if.rd_req_ready;
      wb_take   = !rst && arb_if.wb_req_valid && arb_if.wb_req_ready;
      took_last = rd_take || wb_take;
   endtask

   task automatic wait_drain(input int bound);
      bit done = 0;
      for (int i = 0; i < bound && !done; i++) begin
         @(posedge clk);
         done = (rd_q.size() == 0) && (wb_q.size() == 0) && (exp_mem_q.size() == 0) &&
                (exp_resp_q.size() == 0) && (rd_cnt == 0) && !resp_due && !resp_due_nx;
      end
      check_val("drain", done, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      check_val("idle_after", busy, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit rd_issued;
      arb_if.rd_req_valid = 1'b0;
      arb_if.rd_req_addr  = '0;
      arb_if.wb_req_valid = 1'b0;
      arb_if.wb_req_addr  = '0;
      arb_if.wb_req_data  = '0;
      arb_if.mem_ready    = 1'b0;
      arb_if.mem_rvalid   = 1'b0;
      arb_if.mem_rdata    = '0;

      fork
         forever begin
            @(negedge clk);
            tick();
         end
      join_none

      repeat (3) @(posedge clk);
      #1;
      check_val("rst_mem_valid", arb_if.mem_valid, 1'b0);
      check_val("rst_mem_wen", arb_if.mem_wen, 1'b0);
      check_val("rst_mem_addr", arb_if.mem_addr, 32'h0);
      check_val("rst_mem_wdata", arb_if.mem_wdata, '0);
      check_val("rst_resp_valid", arb_if.rd_resp_valid, 1'b0);
      check_val("rst_busy", busy, 1'b0);
      #1 rst = 1'b0;

      // Single refill
      @(posedge clk); #1;
      exp_mem_q.push_back(mk_tx(1'b0, 32'h0000_1230, '0));
      rd_q.push_back(28'h000_0123);
      wait_drain(60);

      // RAW hazard: same line on both sides, write must go first
`ifdef DCACHE_ARB_PERF_EN
      perf_rd0 = perf_rd; perf_wb0 = perf_wb; perf_raw0 = perf_raw;
`endif
      @(posedge clk); #1;
      exp_mem_q.push_back(mk_tx(1'b1, 32'h0000_4560, {4{32'h1111_2222}}));
      exp_mem_q.push_back(mk_tx(1'b0, 32'h0000_4560, '0));
      rd_q.push_back(28'h000_0456);
      wb_q.push_back(mk_wb(28'h000_0456, {4{32'h1111_2222}}));
      wait_drain(80);
`ifdef DCACHE_ARB_PERF_EN
      check_val("perf_raw", perf_raw - perf_raw0, 32'd1);
      check_val("perf_wb", perf_wb - perf_wb0, 32'd1);
      check_val("perf_rd", perf_rd - perf_rd0, 32'd1);
`endif

      // Starvation: four reads, then the pending write is forced
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++)
         exp_mem_q.push_back(mk_tx(1'b0, 32'h0001_0000 + 32'(i) * 32'h10, '0));
      exp_mem_q.push_back(mk_tx(1'b1, 32'h0002_0000, {4{32'h3333_4444}}));
      for (int i = 4; i < 6; i++)
         exp_mem_q.push_back(mk_tx(1'b0, 32'h0001_0000 + 32'(i) * 32'h10, '0));
      for (int i = 0; i < 6; i++)
         rd_q.push_back(28'h000_1000 + 28'(i));
      wb_q.push_back(mk_wb(28'h000_2000, {4{32'h3333_4444}}));
      wait_drain(200);

      // Streak restarts from zero: reads win again before the write
      @(posedge clk); #1;
      exp_mem_q.push_back(mk_tx(1'b0, 32'h0003_0000, '0));
      exp_mem_q.push_back(mk_tx(1'b0, 32'h0003_0010, '0));
      exp_mem_q.push_back(mk_tx(1'b1, 32'h0004_0000, {4{32'h5555_6666}}));
      rd_q.push_back(28'h000_3000);
      rd_q.push_back(28'h000_3001);
      wb_q.push_back(mk_wb(28'h000_4000, {4{32'h5555_6666}}));
      wait_drain(120);

      // Backpressure on a write with a read queued behind it
      @(posedge clk); #1;
      exp_mem_q.push_back(mk_tx(1'b1, 32'h0000_7890, {4{32'h7777_8888}}));
      exp_mem_q.push_back(mk_tx(1'b0, 32'h0000_0AB0, '0));
      wb_q.push_back(mk_wb(28'h000_0789, {4{32'h7777_8888}}));
      stall_cnt = 5;
      @(posedge clk); #1;
      rd_q.push_back(28'h000_00AB);
      wait_drain(80);
      check_val("stall_consumed", 32'(stall_cnt), 32'd0);

      // Reset while waiting for read data; late data must be dropped
      @(posedge clk); #1;
      exp_mem_q.push_back(mk_tx(1'b0, 32'h0000_CDE0, '0));
      rd_q.push_back(28'h000_0CDE);
      rd_issued = 0;
      for (int i = 0; i < 30 && !rd_issued; i++) begin
         @(posedge clk);
         rd_issued = (exp_mem_q.size() == 0);
      end
      check_val("rd_issued", rd_issued, 1'b1);
      @(negedge clk); #2;
      rd_cnt = 0;
      check_val("busy_rd_wait", busy, 1'b1);
      rst = 1'b1;
      #1;
      check_val("arst_mem_valid", arb_if.mem_valid, 1'b0);
      check_val("arst_busy", busy, 1'b0);
      check_val("arst_resp_valid", arb_if.rd_resp_valid, 1'b0);
      @(negedge clk);
      @(negedge clk); #2;
      rst = 1'b0;
      force_rvalid = 1;
      repeat (5) @(posedge clk);
      #1;
      check_val("post_rst_busy", busy, 1'b0);
      check_val("post_rst_mem_valid", arb_if.mem_valid, 1'b0);
      check_val("post_rst_resp_valid", arb_if.rd_resp_valid, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
